// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//   Wide (32*WORDS-bit) add/subtract built around a single 32-bit
//   carry-increment adder. Operands are captured in one handshake and
//   processed one word per clock, least significant word first. The
//   carry between words is held in a register.
//
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     start_valid/ready     operand handshake (ready only in IDLE)
//     op_sub, cin, a, b     operation select, carry in, operands
//     res_valid/ready       result handshake
//     sum, cout, ovf        result, carry out of top word, signed overflow
//     busy                  high while words are being processed
//
// carry_increment_32_bit
//   32-bit adder built from 4-bit blocks. Each block adds with carry-in 0;
//   the block result is then incremented by the incoming block carry.

module carry_increment_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    localparam int BLK = 4;
    localparam int NB  = 32 / BLK;

    logic [NB:0] c;
    assign c[0] = cin;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [BLK:0]   raw;
        logic [BLK-1:0] p;
        assign raw = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
        assign p   = a[g*BLK +: BLK] ^ b[g*BLK +: BLK];
        assign sum[g*BLK +: BLK] = raw[BLK-1:0] + {{(BLK-1){1'b0}}, c[g]};
        // A block passes its carry in only when every bit propagates.
        assign c[g+1] = raw[BLK] | ((&p) & c[g]);
    end

    assign cout = c[NB];
endmodule

module multiword_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic                  op_sub,
    input  logic                  cin,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [32*WORDS-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy
);
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t state, state_nxt;

    logic [WORDS-1:0][31:0] a_q, b_q, sum_q;
    logic [IW-1:0]          idx;
    logic                   carry_q, cout_q, ovf_q;

    logic [31:0] add_a, add_b, add_sum;
    logic        add_cout;
    logic        accept, last, take;

    assign accept = start_valid && (state == IDLE);
    assign last   = (state == ADD) && (idx == LAST);
    assign take   = res_ready && (state == DONE);

    // Adder sees registered values only.
    assign add_a = a_q[idx];
    assign add_b = b_q[idx];

    carry_increment_32_bit u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ADD;
            ADD:     if (last)   state_nxt = DONE;
            DONE:    if (take)   state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            // Subtraction is a + ~b + 1; the +1 rides in on the word-0 carry.
            b_q     <= op_sub ? ~b : b;
            carry_q <= op_sub ? 1'b1 : cin;
            idx     <= '0;
        end else if (state == ADD) begin
            sum_q[idx] <= add_sum;
            carry_q    <= add_cout;
            idx        <= idx + 1'b1;
            if (last) begin
                cout_q <= add_cout;
                ovf_q  <= (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);
            end
        end
    end

    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign busy        = (state == ADD);
endmodule

// File: tb/tb_multiword_add_sequencer.sv
`timescale 1ps/1fs
module tb_multiword_add_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid, start_ready, op_sub, cin;
    logic [W-1:0] a, b, sum;
    logic         res_valid, res_ready, cout, ovf, busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;
    exp_t sb[$];

    always #25000 clk = ~clk;

    multiword_add_sequencer #(.WORDS(WORDS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_sub      (op_sub),
        .cin         (cin),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int i = 0; i < WORDS; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic sub, input logic c);
        exp_t e;
        logic [W-1:0] be;
        logic [W:0]   full;
        be   = sub ? ~tb : tb;
        full = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : c)};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.v  = (ta[W-1] == be[W-1]) && (full[W-1] != ta[W-1]);
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sready"}, start_ready, 1'b1);
        chk({tag, "_rvalid"}, res_valid, 1'b0);
        chk({tag, "_busy"},   busy, 1'b0);
        chk({tag, "_sum"},    sum, '0);
        chk({tag, "_cout"},   cout, 1'b0);
        chk({tag, "_ovf"},    ovf, 1'b0);
    endtask

    // Drives one accepted operation; returns just after the acceptance edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic sub, input logic c);
        @(negedge clk);
        chk("start_ready_idle", start_ready, 1'b1);
        a = ta; b = tb; op_sub = sub; cin = c; start_valid = 1'b1;
        sb.push_back(model(ta, tb, sub, c));
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = rnd(); b = rnd(); op_sub = $urandom; cin = $urandom;
    endtask

    // Counts edges from acceptance until res_valid; leaves us at a negedge.
    task automatic wait_result(output int cyc, output int bc);
        cyc = 0; bc = 0;
        forever begin
            @(negedge clk);
            if (res_valid) break;
            if (busy) bc++;
            if (cyc > 40) begin
                chk("timeout_res_valid", 1'b0, 1'b1);
                break;
            end
            @(posedge clk);
            cyc++;
        end
    endtask

    // Compares the held result with the scoreboard head and releases it.
    task automatic take_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1'b1, 1'b0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_sum"},  sum,  e.s);
        chk({tag, "_cout"}, cout, e.c);
        chk({tag, "_ovf"},  ovf,  e.v);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_after"}, start_ready, 1'b1);
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic sub, input logic c);
        int cyc, bc;
        start_op(ta, tb, sub, c);
        wait_result(cyc, bc);
        chk({tag, "_lat"}, cyc, WORDS);
        take_result(tag);
    endtask

    initial begin
        int cyc, bc;
        logic [W-1:0] hs;
        logic         hc, hv;
        logic [W-1:0] ones, msb;
        ones = '1;
        msb  = '0;
        msb[W-1] = 1'b1;

        rst_n = 1'b0; res_ready = 1'b0;
        start_valid = 1'b0; op_sub = 1'b0; cin = 1'b0; a = '0; b = '0;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_valid = $urandom; res_ready = $urandom;
            op_sub = $urandom; cin = $urandom; a = rnd(); b = rnd();
        end
        @(negedge clk);
        check_reset_outputs("rst");
        start_valid = 1'b0; res_ready = 1'b0;
        rst_n = 1'b1;

        // Full carry chain: latency and busy width.
        start_op(ones, 1, 1'b0, 1'b0);
        wait_result(cyc, bc);
        chk("chain_lat", cyc, WORDS);
        chk("chain_busy_cycles", bc, WORDS);
        take_result("chain");

        // Subtract: cin must be ignored.
        full_op("sub_borrow", '0, 1, 1'b1, 1'b1);
        full_op("sub_eq", 5, 5, 1'b1, 1'b0);

        // Signed overflow both directions.
        full_op("ovf_add", ~msb, 1, 1'b0, 1'b0);
        full_op("ovf_sub", msb, 1, 1'b1, 1'b0);

        // Add with carry in, and res_ready held high while idle.
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_rr_high", start_ready, 1'b1);
        res_ready = 1'b0;
        full_op("add_cin", 32'hFFFF_FFFF, 0, 1'b0, 1'b1);

        // Random operations.
        for (int i = 0; i < 6; i++)
            full_op("rand", rnd(), rnd(), 1'($urandom), 1'($urandom));

        // Backpressure: result held, start pulses ignored.
        start_op(rnd(), rnd(), 1'b0, 1'b1);
        wait_result(cyc, bc);
        hs = sum; hc = cout; hv = ovf;
        for (int i = 0; i < 10; i++) begin
            start_valid = i[0];
            a = rnd(); b = rnd();
            @(posedge clk);
            @(negedge clk);
            chk("bp_sum",    sum, hs);
            chk("bp_cout",   cout, hc);
            chk("bp_ovf",    ovf, hv);
            chk("bp_sready", start_ready, 1'b0);
            chk("bp_rvalid", res_valid, 1'b1);
        end
        start_valid = 1'b0;
        take_result("bp");
        full_op("bp_next", rnd(), rnd(), 1'b1, 1'b0);

        // Asynchronous reset mid-cycle while a result is held.
        start_op(ones, ones, 1'b0, 1'b1);
        wait_result(cyc, bc);
        @(posedge clk);
        #10000;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst_done");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-ADD after word 2.
        start_op(rnd(), rnd(), 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1000;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst_add");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        full_op("post_rst", 128'h1_0000_0000, 128'hFFFF_FFFF_0000_0000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
